boot_sequencer: RTL and testbench
=================================

Name: boot_sequencer

Overview:
- Sequences the Hack CPU's start-up.
- Holds the CPU in reset while a program image streams in byte-wise from the UART receiver.
- Writes each assembled 16-bit word into instruction ROM through the ROM write port, verifies a trailing checksum, then releases the CPU.
- Sits between the UART RX, the instruction ROM write port and the CPU's rstn input.

Parameters:
- ADDR_W, 15, instruction ROM address width; capacity MAX_WORDS = 2**ADDR_W.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle
- rx_ready  out  1  sequencer accepts byte; transfer occurs when rx_valid & rx_ready
- boot_req  in  1  synchronous pulse: abort and restart loading
- rom_we  out  1  ROM write strobe, one cycle per word
- rom_addr  out  ADDR_W  ROM write address
- rom_wdata  out  16  ROM write data
- cpu_rstn  out  1  CPU reset, active-low; low in every state except RUN
- busy  out  1  loading in progress
- done  out  1  image loaded and verified, CPU running
- err  out  1  length or checksum fault
- words_loaded  out  16  count of words written in current load

Behaviour:
- Reset values:
  - state = HDR_HI, cpu_rstn = 0, rom_we = 0, rom_addr = 0, rom_wdata = 0.
  - busy = 1, done = 0, err = 0, words_loaded = 0, checksum accumulator = 0.
- Image format, big-endian byte order:
  - N: word count, 2 bytes.
  - N data words, 2 bytes each.
  - S: 16-bit modulo-2^16 sum of the data words, 2 bytes. Header and S are excluded from the sum.
- States: HDR_HI, HDR_LO, DAT_HI, DAT_LO, CSUM_HI, CSUM_LO, RUN, ERROR.
  - Every transition fires only on an accepted byte, except RUN and ERROR, which wait for boot_req.
- rx_ready = 1 in HDR_HI through CSUM_LO and 0 in RUN/ERROR. rx_ready is forced to 0 in any cycle where boot_req = 1.
- HDR_HI → HDR_LO: latch N[15:8].
- HDR_LO: latch N[7:0].
  - If N > MAX_WORDS → ERROR.
  - Else if N = 0 → CSUM_HI.
  - Else → DAT_HI.
- DAT_HI → DAT_LO: latch the high byte.
- DAT_LO: assemble the word.
  - Next cycle: rom_we = 1 for exactly one cycle, with rom_addr = words_loaded[ADDR_W-1:0] and rom_wdata = the word.
  - In the same cycle, words_loaded increments and the sum accumulates.
  - If words_loaded + 1 = N → CSUM_HI, else → DAT_HI.
- Latency: the rom_we cycle is the cycle immediately after the low-byte handshake. Back-to-back bytes on consecutive cycles are legal and never overlap writes, since a word needs two bytes.
- CSUM_HI → CSUM_LO: latch S[15:8].
- CSUM_LO: compare {S_hi, byte} to the accumulated sum, including the word written in the same cycle.
  - Match → RUN.
  - Mismatch → ERROR.
- RUN: cpu_rstn = 1 (registered, first high the cycle after entry), done = 1, busy = 0.
- ERROR: err = 1, busy = 0, cpu_rstn = 0. Words already written stay in ROM.
- Address never wraps: the N ≤ MAX_WORDS check guarantees words_loaded < MAX_WORDS at every write.
- boot_req, in any state:
  - Next state is HDR_HI.
  - cpu_rstn drops to 0 the next cycle.
  - err, done, words_loaded and sum clear.
  - boot_req has priority over a same-cycle byte, which is not accepted.
  - A rom_we pending from a DAT_LO handshake in the previous cycle still completes.
- rstn assertion mid-load: all registers return to their reset values immediately (asynchronous); rom_we deasserts at once.

Decomposition:
- Shared package boot_pkg: state encoding localparams (3-bit) and the MAX_WORDS derivation function.
- One sub-module, byte_pair_asm: holds the high byte, emits a 16-bit word plus a one-cycle word_valid on the low byte, and clears on restart.
- Checksum, counter and FSM stay in boot_sequencer.

Test Plan:
- Reset then bytes 00 02 | 12 34 | AB CD | BE 01 → rom_we pulses at addr 0 data 0x1234 and addr 1 data 0xABCD; then RUN, done = 1, cpu_rstn = 1 one cycle after the last byte; words_loaded = 2.
- Bytes 00 01 | 00 05 | 00 06 → checksum mismatch → ERROR; err = 1, cpu_rstn = 0, rx_ready = 0; one ROM write at addr 0 data 0x0005.
- Bytes 00 00 | 00 00 → no rom_we; RUN, done = 1.
- Header 80 01 with ADDR_W = 15 → ERROR right after the second byte; no rom_we.
- boot_req pulsed during RUN, then image 00 01 | 00 07 | 00 07 → cpu_rstn low the next cycle; reload writes addr 0 data 0x0007; returns to RUN.
- rstn asserted after the DAT_HI byte of word 3 → all outputs at reset values asynchronously; a fresh image afterwards loads from addr 0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the Hack CPU boot sequencer: state encoding and ROM capacity helper.
package boot_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [2:0] ST_HDR_HI  = 3'd0;
  localparam logic [2:0] ST_HDR_LO  = 3'd1;
  localparam logic [2:0] ST_DAT_HI  = 3'd2;
  localparam logic [2:0] ST_DAT_LO  = 3'd3;
  localparam logic [2:0] ST_CSUM_HI = 3'd4;
  localparam logic [2:0] ST_CSUM_LO = 3'd5;
  localparam logic [2:0] ST_RUN     = 3'd6;
  localparam logic [2:0] ST_ERROR   = 3'd7;

  typedef enum logic [2:0] {
    HDR_HI  = ST_HDR_HI,
    HDR_LO  = ST_HDR_LO,
    DAT_HI  = ST_DAT_HI,
    DAT_LO  = ST_DAT_LO,
    CSUM_HI = ST_CSUM_HI,
    CSUM_LO = ST_CSUM_LO,
    RUN     = ST_RUN,
    ERROR   = ST_ERROR
  } bootState_t;

  // One bit wider than a word so a 16-bit address space still fits.
  function automatic logic [WORD_W:0] maxWords(input int unsigned addrW);
    return (WORD_W+1)'(1) << addrW;
  endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// UART RX byte stream and instruction ROM write port seen by the boot sequencer.
interface boot_sequencer_if #(
  parameter int unsigned ADDR_W = 15
);
  import boot_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, rom_we, rom_addr, rom_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, rom_we, rom_addr, rom_wdata
  );
endinterface

// File: rtl/boot_sequencer_byte_pair_asm.sv
// Big-endian byte pair assembler: keeps the high byte, presents the full word on the low byte.
module byte_pair_asm
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              byteValid,
  input  logic              isLow,
  input  logic [BYTE_W-1:0] byteIn,
  output logic [WORD_W-1:0] word_c,
  output logic              wordValid_c
);

  logic [BYTE_W-1:0] hiReg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hiReg <= '0;
    end else if (clear) begin
      hiReg <= '0;
    end else if (byteValid && !isLow) begin
      hiReg <= byteIn;
    end
  end

  assign word_c      = {hiReg, byteIn};
  assign wordValid_c = byteValid && isLow && !clear;

endmodule

// File: rtl/boot_sequencer.sv
// Holds the Hack CPU in reset while a checksummed program image is loaded into instruction ROM.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
)(
  input  logic              clk,
  input  logic              rstn,
  boot_sequencer_if.master  bus,
  input  logic              boot_req,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] words_loaded
);

  bootState_t        state;
  logic              rdyReg;
  logic [WORD_W-1:0] nWords;
  logic [WORD_W-1:0] sumAcc;
  logic              romWe;
  logic [ADDR_W-1:0] romAddr;
  logic [WORD_W-1:0] romWdata;

  logic              accept;
  logic              isLow;
  logic [WORD_W-1:0] word_c;
  logic              wordValid_c;

  // boot_req wins over a same-cycle byte, so ready drops combinationally.
  assign bus.rx_ready  = rdyReg && !boot_req;
  assign accept        = bus.rx_valid && bus.rx_ready;
  assign isLow         = (state == HDR_LO) || (state == DAT_LO) || (state == CSUM_LO);
  assign bus.rom_we    = romWe;
  assign bus.rom_addr  = romAddr;
  assign bus.rom_wdata = romWdata;

  byte_pair_asm u_asm (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (boot_req),
    .byteValid   (accept),
    .isLow       (isLow),
    .byteIn      (bus.rx_data),
    .word_c      (word_c),
    .wordValid_c (wordValid_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= HDR_HI;
      rdyReg       <= 1'b1;
      nWords       <= '0;
      sumAcc       <= '0;
      romWe        <= 1'b0;
      romAddr      <= '0;
      romWdata     <= '0;
      cpu_rstn     <= 1'b0;
      busy         <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      romWe <= 1'b0;
      if (boot_req) begin
        state        <= HDR_HI;
        rdyReg       <= 1'b1;
        sumAcc       <= '0;
        cpu_rstn     <= 1'b0;
        busy         <= 1'b1;
        done         <= 1'b0;
        err          <= 1'b0;
        words_loaded <= '0;
      end else if (accept) begin
        case (state)
          HDR_HI:  state <= HDR_LO;
          HDR_LO: begin
            nWords <= word_c;
            if ({1'b0, word_c} > maxWords(ADDR_W)) begin
              state  <= ERROR;
              rdyReg <= 1'b0;
              err    <= 1'b1;
              busy   <= 1'b0;
            end else if (word_c == '0) begin
              state <= CSUM_HI;
            end else begin
              state <= DAT_HI;
            end
          end
          DAT_HI:  state <= DAT_LO;
          DAT_LO: begin
            romWe        <= wordValid_c;
            romAddr      <= ADDR_W'(words_loaded);
            romWdata     <= word_c;
            words_loaded <= words_loaded + WORD_W'(1);
            sumAcc       <= sumAcc + word_c;
            state        <= (words_loaded + WORD_W'(1) == nWords) ? CSUM_HI : DAT_HI;
          end
          CSUM_HI: state <= CSUM_LO;
          CSUM_LO: begin
            rdyReg <= 1'b0;
            busy   <= 1'b0;
            if (word_c == sumAcc) begin
              state    <= RUN;
              cpu_rstn <= 1'b1;
              done     <= 1'b1;
            end else begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: table of images plus hand-written restart/reset sequences.
module tb_boot_sequencer;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned NVEC   = 6;

  typedef struct {
    logic [79:0] img;
    int          len;
    bit          expRun;
    logic [15:0] expWords;
  } vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic boot_req = 1'b0;
  logic cpu_rstn, busy, done, err;
  logic [15:0] words_loaded;

  int nChecks = 0;
  int nPass = 0;
  wr_t expQ[$];
  vec_t vecs[NVEC];

  boot_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  boot_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus.master),
    .boot_req     (boot_req),
    .cpu_rstn     (cpu_rstn),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] getByte(input logic [79:0] img, input int i);
    return img[79-8*i -: 8];
  endfunction

  // Scoreboard: every ROM write is matched against the oldest expected write.
  always @(negedge clk) begin
    if (bus.rom_we === 1'b1) begin
      if (expQ.size() == 0) begin
        check("unexpected_rom_we", 32'(bus.rom_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        check("rom_addr", 32'(bus.rom_addr), 32'(e.addr));
        check("rom_wdata", 32'(bus.rom_wdata), 32'(e.data));
      end
    end
  end

  // Drives one byte, waits for the handshake edge, returns at the following negedge.
  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.rx_ready !== 1'b1) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Independent image model: the writes the sequencer should perform.
  task automatic pushExpected(input vec_t v);
    logic [15:0] n;
    n = {getByte(v.img, 0), getByte(v.img, 1)};
    if (v.len >= 2 && 32'(n) <= (32'd1 << ADDR_W)) begin
      for (int i = 0; i < 32'(n) && 3 + 2*i < v.len; i++) begin
        wr_t w;
        w.addr = ADDR_W'(i);
        w.data = {getByte(v.img, 2 + 2*i), getByte(v.img, 3 + 2*i)};
        expQ.push_back(w);
      end
    end
  endtask

  task automatic runVector(input int idx);
    vec_t v;
    v = vecs[idx];
    pushExpected(v);
    for (int i = 0; i < v.len; i++) sendByte(getByte(v.img, i));
    check($sformatf("v%0d_done", idx), 32'(done), 32'(v.expRun));
    check($sformatf("v%0d_err", idx), 32'(err), 32'(!v.expRun));
    check($sformatf("v%0d_cpu_rstn", idx), 32'(cpu_rstn), 32'(v.expRun));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d_rx_ready", idx), 32'(bus.rx_ready), 32'd0);
    check($sformatf("v%0d_words", idx), 32'(words_loaded), 32'(v.expWords));
    check($sformatf("v%0d_writes_left", idx), 32'(expQ.size()), 32'd0);
  endtask

  task automatic restart(input string tag);
    boot_req = 1'b1;
    #1 check({tag, "_rdy_forced_low"}, 32'(bus.rx_ready), 32'd0);
    @(negedge clk);
    boot_req = 1'b0;
    #1;
    check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'd0);
    check({tag, "_rom_we"}, 32'(bus.rom_we), 32'd0);
    check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    check({tag, "_rom_wdata"}, 32'(bus.rom_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", nChecks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{img: 80'h0002_1234_ABCD_BE01_0000, len: 8,  expRun: 1'b1, expWords: 16'd2};
    vecs[1] = '{img: 80'h0001_0007_0007_0000_0000, len: 6,  expRun: 1'b1, expWords: 16'd1};
    vecs[2] = '{img: 80'h0001_0005_0006_0000_0000, len: 6,  expRun: 1'b0, expWords: 16'd1};
    vecs[3] = '{img: 80'h0000_0000_0000_0000_0000, len: 4,  expRun: 1'b1, expWords: 16'd0};
    vecs[4] = '{img: 80'h8001_0000_0000_0000_0000, len: 2,  expRun: 1'b0, expWords: 16'd0};
    vecs[5] = '{img: 80'h0003_FFFF_0002_0001_0002, len: 10, expRun: 1'b1, expWords: 16'd3};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("por");
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      runVector(i);
      restart($sformatf("restart%0d", i));
    end

    // Header of exactly MAX_WORDS is legal: the sequencer must move on to data, not fault.
    sendByte(8'h80);
    sendByte(8'h00);
    check("maxwords_err", 32'(err), 32'd0);
    check("maxwords_rx_ready", 32'(bus.rx_ready), 32'd1);
    restart("restart_maxwords");

    // Async reset after the high byte of the third word.
    expQ.push_back('{addr: ADDR_W'(0), data: 16'h1111});
    expQ.push_back('{addr: ADDR_W'(1), data: 16'h2222});
    sendByte(8'h00); sendByte(8'h04);
    sendByte(8'h11); sendByte(8'h11);
    sendByte(8'h22); sendByte(8'h22);
    sendByte(8'h33);
    check("midload_words", 32'(words_loaded), 32'd2);
    #2 rstn = 1'b0;
    #1 checkResetValues("async_rst");
    check("async_rst_writes_left", 32'(expQ.size()), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Async reset during a ROM write cycle kills the strobe immediately.
    expQ.push_back('{addr: ADDR_W'(0), data: 16'h0009});
    sendByte(8'h00); sendByte(8'h01);
    sendByte(8'h00); sendByte(8'h09);
    check("we_before_rst", 32'(bus.rom_we), 32'd1);
    #2 rstn = 1'b0;
    #1 check("we_async_drop", 32'(bus.rom_we), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Fresh image after reset loads from address 0.
    runVector(1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
